// File: rtl/fib_datapath_gr10.sv
// Fibonacci datapath slaved to the gr10 sequence controller: five registers, two ORed
// operand buses, an 8-function ALU and the bo/ovf/done status flags.
module fib_datapath_gr10 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic [2:0]   f,
    input  logic         tsw,
    input  logic         tn,
    input  logic         tm,
    input  logic         tp,
    input  logic         tone,
    input  logic         tpp,
    input  logic         tout,
    input  logic         ldn,
    input  logic         ldm,
    input  logic         ldp,
    input  logic         ldpp,
    input  logic         ldout,
    input  logic         over,
    output logic [W-1:0] result,
    output logic         bo,
    output logic         ovf,
    output logic         done
);

    typedef enum logic [2:0] {
        ALU_ZERO = 3'd0,
        ALU_AND  = 3'd1,
        ALU_A    = 3'd2,
        ALU_B    = 3'd3,
        ALU_SUB  = 3'd4,
        ALU_ADD  = 3'd5,
        ALU_OR   = 3'd6,
        ALU_XOR  = 3'd7
    } alu_op_t;

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] n_q;
    logic [W-1:0] m_q;
    logic [W-1:0] p_q;
    logic [W-1:0] pp_q;
    logic [W-1:0] out_q;

    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;
    logic [W-1:0] y;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic         carry;
    logic         a_le_b;
    alu_op_t      op;

    assign op = alu_op_t'(f);

    // Several drivers on one bus simply OR together; an undriven bus reads zero.
    always_comb begin
        bus_a = '0;
        if (tsw) bus_a = bus_a | sw;
        if (tn)  bus_a = bus_a | n_q;
        if (tm)  bus_a = bus_a | m_q;
        if (tp)  bus_a = bus_a | p_q;
    end

    always_comb begin
        bus_b = '0;
        if (tone) bus_b = bus_b | ONE;
        if (tpp)  bus_b = bus_b | pp_q;
        if (tout) bus_b = bus_b | out_q;
    end

    assign sum    = {1'b0, bus_a} + {1'b0, bus_b};
    assign diff   = {1'b0, bus_a} - {1'b0, bus_b};
    assign carry  = sum[W];
    assign a_le_b = diff[W] || (diff[W-1:0] == '0);

    always_comb begin
        y = '0;
        case (op)
            ALU_ZERO: y = '0;
            ALU_AND:  y = bus_a & bus_b;
            ALU_A:    y = bus_a;
            ALU_B:    y = bus_b;
            ALU_SUB:  y = diff[W-1:0];
            ALU_ADD:  y = sum[W-1:0];
            ALU_OR:   y = bus_a | bus_b;
            ALU_XOR:  y = bus_a ^ bus_b;
            default:  y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q   <= '0;
            m_q   <= '0;
            p_q   <= '0;
            pp_q  <= '0;
            out_q <= '0;
        end else begin
            if (ldn)   n_q   <= y;
            if (ldm)   m_q   <= y;
            if (ldp)   p_q   <= y;
            if (ldpp)  pp_q  <= y;
            if (ldout) out_q <= y;
        end
    end

    // bo is the borrow-or-zero result of the last subtract; ldn clears ovf ahead of any set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bo   <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= over;
            if (op == ALU_SUB)
                bo <= a_le_b;
            if (ldn)
                ovf <= 1'b0;
            else if (op == ALU_ADD && ldout && carry)
                ovf <= 1'b1;
        end
    end

    assign result = out_q;

endmodule

// File: tb/tb_fib_datapath_gr10.sv
// Directed bench for fib_datapath_gr10: replays controller sequences and checks
// result/bo/ovf/done against hand-computed values.
module tb_fib_datapath_gr10;

    localparam logic [3:0] A_NONE = 4'b0000;
    localparam logic [3:0] A_SW   = 4'b1000;
    localparam logic [3:0] A_N    = 4'b0100;
    localparam logic [3:0] A_M    = 4'b0010;
    localparam logic [3:0] A_P    = 4'b0001;
    localparam logic [2:0] B_NONE = 3'b000;
    localparam logic [2:0] B_ONE  = 3'b100;
    localparam logic [2:0] B_PP   = 3'b010;
    localparam logic [2:0] B_OUT  = 3'b001;
    localparam logic [4:0] L_NONE = 5'b00000;
    localparam logic [4:0] L_N    = 5'b10000;
    localparam logic [4:0] L_M    = 5'b01000;
    localparam logic [4:0] L_P    = 5'b00100;
    localparam logic [4:0] L_PP   = 5'b00010;
    localparam logic [4:0] L_OUT  = 5'b00001;
    localparam logic [2:0] F_ZERO = 3'd0;
    localparam logic [2:0] F_AND  = 3'd1;
    localparam logic [2:0] F_A    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_SUB  = 3'd4;
    localparam logic [2:0] F_ADD  = 3'd5;
    localparam logic [2:0] F_OR   = 3'd6;
    localparam logic [2:0] F_XOR  = 3'd7;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [2:0] f;
    logic       tsw, tn, tm, tp, tone, tpp, tout;
    logic       ldn, ldm, ldp, ldpp, ldout, over;
    logic [7:0] result;
    logic       bo, ovf, done;

    int tests;
    int failures;

    fib_datapath_gr10 #(.W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (sw),
        .f      (f),
        .tsw    (tsw),
        .tn     (tn),
        .tm     (tm),
        .tp     (tp),
        .tone   (tone),
        .tpp    (tpp),
        .tout   (tout),
        .ldn    (ldn),
        .ldm    (ldm),
        .ldp    (ldp),
        .ldpp   (ldpp),
        .ldout  (ldout),
        .over   (over),
        .result (result),
        .bo     (bo),
        .ovf    (ovf),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one controller cycle, clock it, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic [3:0] asel, input logic [2:0] bsel,
                                 input logic [2:0] func, input logic [4:0] ld,
                                 input logic ovr);
        {tsw, tn, tm, tp}            = asel;
        {tone, tpp, tout}            = bsel;
        f                            = func;
        {ldn, ldm, ldp, ldpp, ldout} = ld;
        over                         = ovr;
        @(posedge clk);
        #1;
        {tsw, tn, tm, tp}            = 4'b0;
        {tone, tpp, tout}            = 3'b0;
        {ldn, ldm, ldp, ldpp, ldout} = 5'b0;
        f                            = F_ZERO;
        over                         = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Copies a register into OUT so it becomes visible on result.
    task automatic readA(input string tag, input logic [3:0] asel, input logic [7:0] expected);
        applyStimulus(asel, B_NONE, F_A, L_OUT, 1'b0);
        checkOutput(tag, result, expected);
    endtask

    // Controller replay: load N, M=N-1, P=PP=1, then the OUT/PP/P/M loop sw-1 times.
    task automatic runFib(input string tag, input logic [7:0] swv);
        logic [7:0] fib_expect [0:4];
        int iters;
        fib_expect[0] = 8'd2;
        fib_expect[1] = 8'd3;
        fib_expect[2] = 8'd5;
        fib_expect[3] = 8'd8;
        fib_expect[4] = 8'd13;
        iters = int'(swv) - 1;
        sw = swv;
        applyStimulus(A_SW, B_NONE, F_A, L_N, 1'b0);
        applyStimulus(A_N, B_ONE, F_SUB, L_M, 1'b0);
        checkOutput({tag, "_bo_init"}, {7'b0, bo}, 8'd0);
        applyStimulus(A_NONE, B_ONE, F_B, L_P | L_PP, 1'b0);
        for (int i = 0; i < iters; i++) begin
            applyStimulus(A_P, B_PP, F_ADD, L_OUT, 1'b0);
            checkOutput($sformatf("%s_out%0d", tag, i), result, fib_expect[i]);
            applyStimulus(A_P, B_NONE, F_A, L_PP, 1'b0);
            applyStimulus(A_NONE, B_OUT, F_B, L_P, 1'b0);
            applyStimulus(A_M, B_ONE, F_SUB, L_M, 1'b0);
            checkOutput($sformatf("%s_bo%0d", tag, i), {7'b0, bo},
                        (i == iters - 1) ? 8'd1 : 8'd0);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst_n    = 1'b1;
        sw       = 8'd0;
        {tsw, tn, tm, tp}            = 4'b0;
        {tone, tpp, tout}            = 3'b0;
        {ldn, ldm, ldp, ldpp, ldout} = 5'b0;
        f    = F_ZERO;
        over = 1'b0;

        // Bring the design to a known state first.
        rst_n = 1'b0;
        applyStimulus(A_NONE, B_NONE, F_ZERO, L_NONE, 1'b0);
        rst_n = 1'b1;

        // Test 1: everything nonzero, then reset with a competing OUT load.
        sw = 8'd7;
        applyStimulus(A_SW, B_NONE, F_A, L_N | L_M | L_P | L_PP | L_OUT, 1'b0);
        checkOutput("pre_out7", result, 8'd7);
        applyStimulus(A_NONE, B_ONE, F_SUB, L_NONE, 1'b0);
        sw = 8'hFF;
        applyStimulus(A_SW, B_PP, F_ADD, L_OUT, 1'b1);
        checkOutput("pre_result", result, 8'h06);
        checkOutput("pre_bo", {7'b0, bo}, 8'd1);
        checkOutput("pre_ovf", {7'b0, ovf}, 8'd1);
        checkOutput("pre_done", {7'b0, done}, 8'd1);
        rst_n = 1'b0;
        applyStimulus(A_SW, B_ONE, F_ADD, L_OUT, 1'b1);
        rst_n = 1'b1;
        checkOutput("rst_result", result, 8'd0);
        checkOutput("rst_bo", {7'b0, bo}, 8'd0);
        checkOutput("rst_ovf", {7'b0, ovf}, 8'd0);
        checkOutput("rst_done", {7'b0, done}, 8'd0);
        readA("rst_n_reg", A_N, 8'd0);
        readA("rst_m_reg", A_M, 8'd0);
        readA("rst_p_reg", A_P, 8'd0);
        applyStimulus(A_NONE, B_PP, F_B, L_OUT, 1'b0);
        checkOutput("rst_pp_reg", result, 8'd0);

        // Test 2: Fibonacci run from sw=6.
        runFib("fib6", 8'd6);

        // Test 3: bo boundary around M=1, 2, 0.
        applyStimulus(A_NONE, B_ONE, F_B, L_M, 1'b0);
        applyStimulus(A_M, B_ONE, F_SUB, L_M, 1'b0);
        checkOutput("bo_m1", {7'b0, bo}, 8'd1);
        readA("m1_dec", A_M, 8'd0);
        sw = 8'd2;
        applyStimulus(A_SW, B_NONE, F_A, L_M, 1'b0);
        applyStimulus(A_M, B_ONE, F_SUB, L_NONE, 1'b0);
        checkOutput("bo_m2", {7'b0, bo}, 8'd0);
        applyStimulus(A_NONE, B_NONE, F_ZERO, L_M, 1'b0);
        applyStimulus(A_M, B_ONE, F_SUB, L_OUT, 1'b0);
        checkOutput("m0_y", result, 8'hFF);
        checkOutput("bo_m0", {7'b0, bo}, 8'd1);
        applyStimulus(A_SW, B_ONE, F_ADD, L_NONE, 1'b0);
        checkOutput("bo_hold", {7'b0, bo}, 8'd1);

        // Test 4: add overflow, stickiness and clearing by ldn.
        sw = 8'd200;
        applyStimulus(A_SW, B_NONE, F_A, L_P, 1'b0);
        sw = 8'd100;
        applyStimulus(A_SW, B_NONE, F_A, L_PP, 1'b0);
        applyStimulus(A_P, B_PP, F_ADD, L_M, 1'b0);
        checkOutput("ovf_no_ldout", {7'b0, ovf}, 8'd0);
        applyStimulus(A_P, B_PP, F_ADD, L_OUT, 1'b0);
        checkOutput("ovf_result", result, 8'd44);
        checkOutput("ovf_set", {7'b0, ovf}, 8'd1);
        applyStimulus(A_SW, B_ONE, F_ADD, L_OUT, 1'b0);
        checkOutput("ovf_add101", result, 8'd101);
        checkOutput("ovf_sticky", {7'b0, ovf}, 8'd1);
        applyStimulus(A_SW, B_NONE, F_A, L_N, 1'b0);
        checkOutput("ovf_clear", {7'b0, ovf}, 8'd0);
        applyStimulus(A_P, B_PP, F_ADD, L_OUT, 1'b0);
        applyStimulus(A_P, B_PP, F_ADD, L_N | L_OUT, 1'b0);
        checkOutput("ovf_clear_wins", {7'b0, ovf}, 8'd0);

        // Test 5: bus OR, undriven bus, remaining ALU functions and done.
        sw = 8'hF0;
        applyStimulus(A_SW, B_NONE, F_A, L_N, 1'b0);
        sw = 8'h0F;
        applyStimulus(A_SW | A_N, B_NONE, F_A, L_M, 1'b0);
        readA("bus_or", A_M, 8'hFF);
        applyStimulus(A_NONE, B_NONE, F_A, L_P, 1'b0);
        readA("bus_none", A_P, 8'h00);
        sw = 8'h3C;
        applyStimulus(A_SW, B_NONE, F_A, L_PP, 1'b0);
        applyStimulus(A_N, B_PP, F_AND, L_OUT, 1'b0);
        checkOutput("alu_and", result, 8'h30);
        applyStimulus(A_N, B_PP, F_OR, L_OUT, 1'b0);
        checkOutput("alu_or", result, 8'hFC);
        applyStimulus(A_N, B_PP, F_XOR, L_OUT, 1'b1);
        checkOutput("alu_xor", result, 8'hCC);
        checkOutput("done_set", {7'b0, done}, 8'd1);
        applyStimulus(A_N, B_PP, F_B, L_OUT, 1'b0);
        checkOutput("alu_b", result, 8'h3C);
        checkOutput("done_clr", {7'b0, done}, 8'd0);
        applyStimulus(A_N, B_PP, F_SUB, L_OUT, 1'b0);
        checkOutput("alu_sub", result, 8'hB4);
        applyStimulus(A_N, B_PP, F_ZERO, L_OUT, 1'b0);
        checkOutput("alu_zero", result, 8'h00);

        // Test 6: reset between the OUT and PP loads, then a fresh run from sw=5.
        sw = 8'd6;
        applyStimulus(A_SW, B_NONE, F_A, L_N, 1'b0);
        applyStimulus(A_N, B_ONE, F_SUB, L_M, 1'b0);
        applyStimulus(A_NONE, B_ONE, F_B, L_P | L_PP, 1'b0);
        applyStimulus(A_P, B_PP, F_ADD, L_OUT, 1'b0);
        checkOutput("mid_out", result, 8'd2);
        rst_n = 1'b0;
        applyStimulus(A_P, B_NONE, F_A, L_PP, 1'b0);
        rst_n = 1'b1;
        checkOutput("mid_rst_result", result, 8'd0);
        applyStimulus(A_NONE, B_PP, F_B, L_OUT, 1'b0);
        checkOutput("mid_rst_pp", result, 8'd0);
        readA("mid_rst_p", A_P, 8'd0);
        readA("mid_rst_m", A_M, 8'd0);
        runFib("fib5", 8'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
